// File: rtl/hardcloud_top_example_axis_source_if.sv
// AXI4-Stream bundle between the example source and its consumer.
// The master drives payload and valid; the slave drives ready.
interface hardcloud_top_example_axis_source_if #(
  parameter int DATA_W = 512
) ();
  logic                tvalid;
  logic                tready;
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/hardcloud_top_example_axis_source.sv
// AXI4-Stream source for the example adder: on start, emits ceil(size/B) beats
// of an incrementing per-lane pattern, marks the final beat, then pulses done.
module hardcloud_top_example_axis_source #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_ADDER_BIT_WIDTH  = 32,
  parameter int C_XFER_SIZE_WIDTH  = 32
) (
  input  logic                         m_axis_aclk,
  input  logic                         m_axis_aresetn,
  input  logic                         ctrl_start,
  input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
  input  logic [C_ADDER_BIT_WIDTH-1:0] ctrl_seed,
  output logic                         ctrl_busy,
  output logic                         ctrl_done,
  hardcloud_top_example_axis_source_if.master m_axis
);

  localparam int DW = C_AXIS_TDATA_WIDTH;
  localparam int AW = C_ADDER_BIT_WIDTH;
  localparam int XW = C_XFER_SIZE_WIDTH;
  localparam int B  = DW / 8;
  localparam int L  = DW / AW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DONE
  } state_t;

  state_t          r_state;
  logic            r_tvalid;
  logic            r_tlast;
  logic [DW-1:0]   r_tdata;
  logic [B-1:0]    r_tkeep;
  logic [B-1:0]    r_last_keep;
  logic [AW-1:0]   r_next_base;
  logic [XW-1:0]   r_beats_left;
  logic            r_busy;
  logic            r_done;

  logic [XW-1:0]   w_rem;
  logic [XW-1:0]   w_n_beats;
  logic [B-1:0]    w_last_keep;

  // Lane k of a beat whose lane 0 holds 'base'; wrap-around is intentional.
  function automatic logic [DW-1:0] lane_pattern(input logic [AW-1:0] base);
    logic [DW-1:0] p;
    p = '0;
    for (int k = 0; k < L; k++) begin
      p[k*AW +: AW] = base + AW'(k);
    end
    return p;
  endfunction

  // Quotient plus a rounding bit avoids the overflow of (size + B - 1) / B.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_rem       = ctrl_xfer_size_in_bytes % XW'(B);
    w_n_beats   = ctrl_xfer_size_in_bytes / XW'(B) + XW'(w_rem != '0);
    w_last_keep = '1;
    for (int i = 0; i < B; i++) begin
      w_last_keep[i] = (w_rem == '0) || (XW'(i) < w_rem);
    end
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      r_state      <= S_IDLE;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_tdata      <= '0;
      r_tkeep      <= '0;
      r_last_keep  <= '0;
      r_next_base  <= '0;
      r_beats_left <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every branch
      // reads the values from before this edge.
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
          if (ctrl_start) begin
            r_busy      <= 1'b1;
            r_last_keep <= w_last_keep;
            if (w_n_beats == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state      <= S_SEND;
              r_tvalid     <= 1'b1;
              r_tdata      <= lane_pattern(ctrl_seed);
              r_next_base  <= ctrl_seed + AW'(L);
              r_beats_left <= w_n_beats - XW'(1);
              r_tlast      <= (w_n_beats == XW'(1));
              r_tkeep      <= (w_n_beats == XW'(1)) ? w_last_keep : '1;
            end
          end
        end

        S_SEND: begin
          if (r_tvalid && m_axis.tready) begin
            if (r_tlast) begin
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
              r_state  <= S_DONE;
              r_done   <= 1'b1;
            end else begin
              // Preload the following beat so a held-high tready sees no bubbles.
              r_tdata      <= lane_pattern(r_next_base);
              r_next_base  <= r_next_base + AW'(L);
              r_beats_left <= r_beats_left - XW'(1);
              r_tlast      <= (r_beats_left == XW'(1));
              r_tkeep      <= (r_beats_left == XW'(1)) ? r_last_keep : '1;
            end
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tdata  = r_tdata;
  assign m_axis.tkeep  = r_tkeep;
  assign m_axis.tlast  = r_tlast;
  assign ctrl_busy     = r_busy;
  assign ctrl_done     = r_done;

endmodule
